uart_tx_fifo: RTL

//  8N1 serial transmitter with an input byte FIFO. Drives the SoC ser_rx line from a

---
 rtl/uart_tx_fifo_pkg.sv | 19 +
 rtl/uart_tx_fifo_if.sv | 17 +
 rtl/uart_tx_fifo_sync_fifo.sv | 53 +++++
 rtl/uart_tx_fifo.sv | 132 +++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_fifo_pkg : shared FSM encodings and framing constants for the UART TX.
// Rev 1.0
// ----------------------------------------------------------------------------
package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  localparam int c_min_div   = 2;
  localparam int c_data_bits = 8;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_fifo_if : valid/ready byte stream feeding the UART transmitter.
// Rev 1.0
// ----------------------------------------------------------------------------
interface uart_tx_fifo_if;
  import uart_tx_fifo_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [c_data_bits-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo_sync_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_fifo_sync_fifo : registered-pointer synchronous FIFO with level output.
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_tx_fifo_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        head,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);
  localparam int c_aw = $clog2(DEPTH);
  localparam logic [c_aw:0] c_ptr_one = (c_aw+1)'(1);

  logic [c_aw:0]      r_wr_ptr;
  logic [c_aw:0]      r_rd_ptr;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic               w_do_push;
  logic               w_do_pop;

  // The extra pointer MSB separates a full FIFO from an empty one.
  assign full      = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign level     = r_wr_ptr - r_rd_ptr;
  assign head      = r_mem[r_rd_ptr[c_aw-1:0]];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[c_aw-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_fifo : 8N1 serial transmitter fed from a byte FIFO.
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [DIV_WIDTH-1:0]         cfg_divider,
  uart_tx_fifo_if.slave                in_if,
  output logic                         ser_tx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
  localparam logic [DIV_WIDTH-1:0] c_div_min = DIV_WIDTH'(c_min_div);
  localparam logic [DIV_WIDTH-1:0] c_div_one = DIV_WIDTH'(1);
  localparam logic [2:0]           c_last_bit = 3'(c_data_bits - 1);

  tx_state_t              r_state;
  tx_state_t              w_state_nxt;
  logic [DIV_WIDTH-1:0]   r_div_q;
  logic [DIV_WIDTH-1:0]   r_cnt;
  logic [DIV_WIDTH-1:0]   w_div_new;
  logic [2:0]             r_bit_idx;
  logic [c_data_bits-1:0] r_shift;
  logic [c_data_bits-1:0] w_head;
  logic                   r_ser_tx;
  logic                   r_stop_tail;
  logic                   w_ser_nxt;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_bit_end;

  assign in_if.in_ready = ~w_full;
  assign w_push         = in_if.in_valid & ~w_full;
  assign w_bit_end      = (r_cnt == '0);
  assign w_div_new      = (cfg_divider < c_div_min) ? c_div_min : cfg_divider;

  uart_tx_fifo_sync_fifo #(
    .WIDTH (c_data_bits),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (w_push),
    .push_data (in_if.in_data),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .level     (fifo_level)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_ser_nxt   = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_ser_nxt = 1'b0;
        if (w_bit_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_ser_nxt = r_shift[0];
        if (w_bit_end && (r_bit_idx == c_last_bit)) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        // Chain straight into the next start bit when another byte is waiting.
        if (w_bit_end) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_div_q     <= c_div_min;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_ser_tx    <= 1'b1;
      r_stop_tail <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ser_tx    <= w_ser_nxt;
      r_stop_tail <= (r_state != S_IDLE);
      if (w_pop) begin
        r_shift   <= w_head;
        r_div_q   <= w_div_new;
        r_cnt     <= w_div_new - c_div_one;
        r_bit_idx <= '0;
      end else if (r_state != S_IDLE) begin
        if (w_bit_end) begin
          r_cnt <= r_div_q - c_div_one;
          if (r_state == S_DATA) begin
            r_shift   <= r_shift >> 1;
            r_bit_idx <= r_bit_idx + 3'd1;
          end
        end else begin
          r_cnt <= r_cnt - c_div_one;
        end
      end
    end
  end

  // The line lags the FSM by one register, so busy covers that final stop cycle.
  assign ser_tx = r_ser_tx;
  assign busy   = (r_state != S_IDLE) || (fifo_level != '0) || r_stop_tail;

endmodule
`default_nettype wire
